// File: rtl/ser_rx_fifo.sv
// UART 8N1 receiver (8E1 with parity_err output when SER_RX_PARITY_EN is defined) feeding a FWFT byte FIFO.
// Latency: byte pushed one cycle after the stop-bit sample, rx_valid/rx_data registered one cycle after push.
// Backpressure: rx_valid/rx_ready pop; a byte completing while the FIFO is full is dropped with an overrun pulse.
module ser_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     ser_rx,
    input  logic [DIV_W-1:0]         cfg_div,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     frame_err,
    output logic                     overrun,
`ifdef SER_RX_PARITY_EN
    output logic                     parity_err,
`endif
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef SER_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif

    // ------------------------------------------------------------------
    // Input synchroniser and edge detect
    // ------------------------------------------------------------------
    logic sync1;
    logic rx_s;
    logic rx_prev;
    logic fall_edge;

    // Two-flop synchroniser plus one history flop; all idle high so reset never fakes a start edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= ser_rx;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    assign fall_edge = rx_prev & ~rx_s;

    // ------------------------------------------------------------------
    // Receive FSM and bit-period divider
    // ------------------------------------------------------------------
    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_eff;
    logic [2:0]       idx;
    logic [7:0]       shreg;
    logic             push_req;
    logic             cnt_exp;
`ifdef SER_RX_PARITY_EN
    logic             par_bad;
`endif

    // Periods below 4 cycles leave no room for the half-period start-bit centring.
    assign div_eff = (cfg_div < DIV_W'(4)) ? DIV_W'(4) : cfg_div;
    // cnt is loaded with (period - 1) on entry, so expiry lands exactly one period after entry.
    assign cnt_exp = (cnt == '0);

    // Frame sequencing; push_req and the error pulses are registered one-cycle strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            div_q     <= DIV_W'(4);
            idx       <= '0;
            shreg     <= '0;
            push_req  <= 1'b0;
            frame_err <= 1'b0;
`ifdef SER_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            push_req  <= 1'b0;
            frame_err <= 1'b0;
`ifdef SER_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (fall_edge) begin
                        // The period is latched here so mid-frame cfg_div changes wait for the next frame.
                        state <= START;
                        div_q <= div_eff;
                        cnt   <= (div_eff >> 1) - DIV_W'(1);
                    end
                end
                START: begin
                    if (cnt_exp) begin
                        if (!rx_s) begin
                            state <= DATA;
                            idx   <= '0;
                            cnt   <= div_q - DIV_W'(1);
                        end else begin
                            // Line back high at mid start bit: treat as a glitch.
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_exp) begin
                        shreg[idx] <= rx_s;
                        cnt        <= div_q - DIV_W'(1);
                        if (idx == 3'd7) begin
`ifdef SER_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
`ifdef SER_RX_PARITY_EN
                PARITY: begin
                    if (cnt_exp) begin
                        // Even parity: data bits plus parity bit must XOR to zero.
                        par_bad <= rx_s ^ (^shreg);
                        state   <= STOP;
                        cnt     <= div_q - DIV_W'(1);
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt_exp) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
`ifdef SER_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err <= 1'b1;
                            end else begin
                                push_req <= 1'b1;
                            end
`else
                            push_req <= 1'b1;
`endif
                        end else begin
                            // Framing error wins over parity; byte is discarded.
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                BRK: begin
                    // A held-low line stays here, so it reports only one framing error.
                    if (rx_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [7:0]    head_next;
    logic          full;
    logic          do_pop;
    logic          wr_en;
    logic          drop;

    assign full   = (count == CW'(DEPTH));
    assign do_pop = rx_valid & rx_ready;
    // When full, a simultaneous pop frees the slot the push needs.
    assign wr_en  = push_req & (~full | do_pop);
    assign drop   = push_req & full & ~do_pop;
    assign rd_nxt = rd_ptr + AW'(1);
    assign fill   = count;

    // Next occupancy and the byte that will sit at the head after this cycle.
    always_comb begin
        count_next = count;
        if (wr_en && !do_pop) begin
            count_next = count + CW'(1);
        end else if (!wr_en && do_pop) begin
            count_next = count - CW'(1);
        end
        head_next = rx_data;
        if (count_next != '0) begin
            if (count == '0 || (do_pop && count == CW'(1))) begin
                head_next = shreg;
            end else if (do_pop) begin
                head_next = mem[rd_nxt];
            end else begin
                head_next = mem[rd_ptr];
            end
        end
    end

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= shreg;
        end
    end

    // Pointer/occupancy bookkeeping with registered head, valid and overrun strobe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            overrun  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_nxt;
            end
            count    <= count_next;
            rx_valid <= (count_next != '0);
            rx_data  <= head_next;
            overrun  <= drop;
        end
    end

endmodule
